// File: rtl/mix_col_seq.sv
// Iterative AES forward MixColumns engine: transforms COLS_PER_CYCLE columns per clock
// in place, with valid/ready handshakes on both the input and the output side.
module mix_col_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
      $error("mix_col_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  // A step of 4 wraps the 2-bit counter to 0, which is harmless since the state is done.
  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           st_q, st_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [3:0][31:0] dat_q, dat_d;   // word 3 holds column 0
  logic             ov_q, ov_d;
  logic [1:0]       idx;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] x0, x1, x2, x3;
    x0 = c[31:24];
    x1 = c[23:16];
    x2 = c[15:8];
    x3 = c[7:0];
    return {xt(x0) ^ xt(x1) ^ x1 ^ x2 ^ x3,
            x0 ^ xt(x1) ^ xt(x2) ^ x2 ^ x3,
            x0 ^ x1 ^ xt(x2) ^ xt(x3) ^ x3,
            xt(x0) ^ x0 ^ x1 ^ x2 ^ xt(x3)};
  endfunction

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    dat_d = dat_q;
    ov_d  = ov_q;
    idx   = '0;
    case (st_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          dat_d = in_data;
          cnt_d = '0;
          st_d  = BUSY;
        end
      end
      BUSY: begin
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
          idx = cnt_q + 2'(i);
          dat_d[~idx] = mix_col(dat_q[~idx]);
        end
        cnt_d = cnt_q + STEP;
        if (cnt_q == LAST_CNT) begin
          st_d = DONE;
          ov_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_d = 1'b0;
          st_d = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= IDLE;
      cnt_q <= '0;
      dat_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      dat_q <= dat_d;
      ov_q  <= ov_d;
    end
  end

  assign in_ready  = (st_q == IDLE) && !rst;
  assign out_valid = ov_q;
  assign out_data  = dat_q;

endmodule
